pb_fb_rr_mbus_arbiter: RTL and testbench

//  Shares one frontend memory bus (mbus, e.g. handshake_cmd_sram) between the CPU ibus and dbus.

---
 rtl/pb_fb_rr_mbus_arbiter.sv | 151 +++++++++++++++
 tb/tb_pb_fb_rr_mbus_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_fb_rr_mbus_arbiter.sv
// pb_fb_rr_mbus_arbiter
// Shares one frontend memory bus between the CPU instruction bus (ibus) and
// data bus (dbus). Commands (A channel) are granted round-robin; the id of
// every accepted command is queued so responses (B channel) are steered back
// to the issuing master strictly in command order.
//
// Handshake: on every channel a beat transfers in the cycle where VALID and
// READY are both high. A VALID, once raised, is held with stable payload
// until READY is seen. READY may depend on VALID only through the arbitration
// select, and no READY here depends on a same-cycle response pop.
module pb_fb_rr_mbus_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int OUTSTANDING = 2,
  parameter int OW          = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  // ibus (read-only master)
  input  logic            fb_ibus_AVALID,
  output logic            fb_ibus_AREADY,
  input  logic [AW-1:0]   fb_ibus_AADDR,
  input  logic [1:0]      fb_ibus_AEXC,
  output logic            fb_ibus_BVALID,
  input  logic            fb_ibus_BREADY,
  output logic [DW-1:0]   fb_ibus_BDATA,
  output logic [1:0]      fb_ibus_BEXC,
  // dbus (read/write master)
  input  logic            fb_dbus_AVALID,
  output logic            fb_dbus_AREADY,
  input  logic [AW-1:0]   fb_dbus_AADDR,
  input  logic [DW-1:0]   fb_dbus_ADATA,
  input  logic [DW/8-1:0] fb_dbus_AWMSK,
  input  logic [1:0]      fb_dbus_AEXC,
  output logic            fb_dbus_BVALID,
  input  logic            fb_dbus_BREADY,
  output logic [DW-1:0]   fb_dbus_BDATA,
  output logic [1:0]      fb_dbus_BEXC,
  // shared memory bus (slave side)
  output logic            fb_mbus_AVALID,
  input  logic            fb_mbus_AREADY,
  output logic [AW-1:0]   fb_mbus_AADDR,
  output logic [DW-1:0]   fb_mbus_ADATA,
  output logic [DW/8-1:0] fb_mbus_AWMSK,
  output logic [1:0]      fb_mbus_AEXC,
  input  logic            fb_mbus_BVALID,
  output logic            fb_mbus_BREADY,
  input  logic [DW-1:0]   fb_mbus_BDATA,
  input  logic [1:0]      fb_mbus_BEXC
);

  localparam int              CW       = OW + 1;
  localparam logic [CW-1:0]   CNT_FULL = CW'(OUTSTANDING);
  localparam logic [OW-1:0]   PTR_LAST = OW'(OUTSTANDING - 1);

  // Master ids: 0 = ibus, 1 = dbus.
  logic          lock_vld;
  logic          lock_id;
  logic          last_id;
  logic [CW-1:0] cnt;
  logic [OW-1:0] wr_ptr;
  logic [OW-1:0] rd_ptr;
  logic          id_fifo [OUTSTANDING];

  logic full;
  logic a_en;
  logic b_en;
  logic sel;
  logic head;
  logic a_hs;
  logic b_hs;

  function automatic logic [OW-1:0] ptr_next(input logic [OW-1:0] p);
    ptr_next = (p == PTR_LAST) ? '0 : p + OW'(1);
  endfunction

  // Grants stop while the id queue is full. Reset also masks both channels so
  // nothing is offered or accepted while rst_n is low, whatever the state.
  assign full = (cnt == CNT_FULL);
  assign a_en = rst_n & ~full;
  assign b_en = rst_n & (cnt != '0);
  assign head = id_fifo[rd_ptr];

  // Arbitration select: a stalled command keeps its master, otherwise round-robin.
  always_comb begin
    sel = fb_dbus_AVALID;
    if (lock_vld) begin
      sel = lock_id;
    end else if (fb_ibus_AVALID && fb_dbus_AVALID) begin
      sel = ~last_id;
    end
  end

  // A channel mux; ibus never writes, so its data and mask are forced to zero.
  assign fb_mbus_AVALID = (sel ? fb_dbus_AVALID : fb_ibus_AVALID) & a_en;
  assign fb_mbus_AADDR  = sel ? fb_dbus_AADDR : fb_ibus_AADDR;
  assign fb_mbus_ADATA  = sel ? fb_dbus_ADATA : '0;
  assign fb_mbus_AWMSK  = sel ? fb_dbus_AWMSK : '0;
  assign fb_mbus_AEXC   = sel ? fb_dbus_AEXC  : fb_ibus_AEXC;
  assign fb_ibus_AREADY = ~sel & fb_mbus_AREADY & a_en;
  assign fb_dbus_AREADY =  sel & fb_mbus_AREADY & a_en;
  assign a_hs           = fb_mbus_AVALID & fb_mbus_AREADY;

  // B channel routing to the master at the head of the id queue. A response
  // arriving with nothing outstanding is left unacknowledged.
  assign fb_ibus_BVALID = b_en & ~head & fb_mbus_BVALID;
  assign fb_dbus_BVALID = b_en &  head & fb_mbus_BVALID;
  assign fb_mbus_BREADY = b_en & (head ? fb_dbus_BREADY : fb_ibus_BREADY);
  assign fb_ibus_BDATA  = fb_mbus_BDATA;
  assign fb_ibus_BEXC   = fb_mbus_BEXC;
  assign fb_dbus_BDATA  = fb_mbus_BDATA;
  assign fb_dbus_BEXC   = fb_mbus_BEXC;
  assign b_hs           = fb_mbus_BVALID & fb_mbus_BREADY;

  // Control state: stall lock, round-robin history, queue pointers and count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      last_id  <= 1'b1;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (a_hs) begin
        lock_vld <= 1'b0;
        last_id  <= sel;
        wr_ptr   <= ptr_next(wr_ptr);
      end else if (fb_mbus_AVALID) begin
        lock_vld <= 1'b1;
        lock_id  <= sel;
      end
      if (b_hs) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({a_hs, b_hs})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Id queue storage; contents are only meaningful below cnt, so no reset.
  always_ff @(posedge clk) begin
    if (a_hs) begin
      id_fifo[wr_ptr] <= sel;
    end
  end

endmodule

// File: tb/tb_pb_fb_rr_mbus_arbiter.sv
// Bench for pb_fb_rr_mbus_arbiter: a directed vector table walked one cycle
// per entry, then a streaming sequence with a small slave and an ordered
// response scoreboard.
module tb_pb_fb_rr_mbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] K = 32'h5A5A_5A5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            ibus_AVALID, ibus_AREADY, ibus_BVALID, ibus_BREADY;
  logic [AW-1:0]   ibus_AADDR;
  logic [1:0]      ibus_AEXC, ibus_BEXC;
  logic [DW-1:0]   ibus_BDATA;
  logic            dbus_AVALID, dbus_AREADY, dbus_BVALID, dbus_BREADY;
  logic [AW-1:0]   dbus_AADDR;
  logic [DW-1:0]   dbus_ADATA, dbus_BDATA;
  logic [DW/8-1:0] dbus_AWMSK;
  logic [1:0]      dbus_AEXC, dbus_BEXC;
  logic            mbus_AVALID, mbus_AREADY, mbus_BVALID, mbus_BREADY;
  logic [AW-1:0]   mbus_AADDR;
  logic [DW-1:0]   mbus_ADATA, mbus_BDATA;
  logic [DW/8-1:0] mbus_AWMSK;
  logic [1:0]      mbus_AEXC, mbus_BEXC;

  pb_fb_rr_mbus_arbiter #(.AW(AW), .DW(DW), .OUTSTANDING(2), .OW(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .fb_ibus_AVALID(ibus_AVALID), .fb_ibus_AREADY(ibus_AREADY),
    .fb_ibus_AADDR(ibus_AADDR), .fb_ibus_AEXC(ibus_AEXC),
    .fb_ibus_BVALID(ibus_BVALID), .fb_ibus_BREADY(ibus_BREADY),
    .fb_ibus_BDATA(ibus_BDATA), .fb_ibus_BEXC(ibus_BEXC),
    .fb_dbus_AVALID(dbus_AVALID), .fb_dbus_AREADY(dbus_AREADY),
    .fb_dbus_AADDR(dbus_AADDR), .fb_dbus_ADATA(dbus_ADATA),
    .fb_dbus_AWMSK(dbus_AWMSK), .fb_dbus_AEXC(dbus_AEXC),
    .fb_dbus_BVALID(dbus_BVALID), .fb_dbus_BREADY(dbus_BREADY),
    .fb_dbus_BDATA(dbus_BDATA), .fb_dbus_BEXC(dbus_BEXC),
    .fb_mbus_AVALID(mbus_AVALID), .fb_mbus_AREADY(mbus_AREADY),
    .fb_mbus_AADDR(mbus_AADDR), .fb_mbus_ADATA(mbus_ADATA),
    .fb_mbus_AWMSK(mbus_AWMSK), .fb_mbus_AEXC(mbus_AEXC),
    .fb_mbus_BVALID(mbus_BVALID), .fb_mbus_BREADY(mbus_BREADY),
    .fb_mbus_BDATA(mbus_BDATA), .fb_mbus_BEXC(mbus_BEXC)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // bits: rst iv dv ar bv ibr dbr | mav sel iar dar ibv dbv mbr
  typedef struct packed {
    logic [7:0] tag;
    logic rst, iv, dv, ar, bv, ibr, dbr;
    logic mav, sel, iar, dar, ibv, dbv, mbr;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  vec_t v;

  function automatic vec_t mk(input logic [7:0] tag, input logic [6:0] ins, input logic [6:0] outs);
    mk = {tag, ins, outs};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ibus_AVALID = 0; ibus_AADDR = '0; ibus_AEXC = 2'b01; ibus_BREADY = 0;
    dbus_AVALID = 0; dbus_AADDR = '0; dbus_ADATA = '0; dbus_AWMSK = '0;
    dbus_AEXC = 2'b10; dbus_BREADY = 0;
    mbus_AREADY = 0; mbus_BVALID = 0; mbus_BDATA = '0; mbus_BEXC = '0;
  endtask

  task automatic drive_vec(input vec_t x);
    rst_n       = x.rst;
    ibus_AVALID = x.iv;
    ibus_AADDR  = 32'h1000_0000 | 32'(x.tag);
    dbus_AVALID = x.dv;
    dbus_AADDR  = 32'h2000_0000 | 32'(x.tag);
    dbus_ADATA  = 32'hDA7A_0000 | 32'(x.tag);
    dbus_AWMSK  = x.tag[3:0] | 4'b1000;
    mbus_AREADY = x.ar;
    mbus_BVALID = x.bv;
    mbus_BDATA  = 32'hB000_0000 | 32'(x.tag);
    mbus_BEXC   = x.tag[1:0];
    ibus_BREADY = x.ibr;
    dbus_BREADY = x.dbr;
  endtask

  task automatic check_vec(input int i, input vec_t x);
    logic [31:0] e_addr, e_data, e_bdata;
    logic [3:0]  e_wmsk;
    logic [1:0]  e_exc;
    e_addr  = x.sel ? (32'h2000_0000 | 32'(x.tag)) : (32'h1000_0000 | 32'(x.tag));
    e_data  = x.sel ? (32'hDA7A_0000 | 32'(x.tag)) : 32'h0;
    e_wmsk  = x.sel ? (x.tag[3:0] | 4'b1000) : 4'h0;
    e_exc   = x.sel ? 2'b10 : 2'b01;
    e_bdata = 32'hB000_0000 | 32'(x.tag);
    chk($sformatf("v%0d mbus_AVALID", i), 64'(mbus_AVALID), 64'(x.mav));
    if (x.mav) begin
      chk($sformatf("v%0d mbus_AADDR", i), 64'(mbus_AADDR), 64'(e_addr));
      chk($sformatf("v%0d mbus_ADATA", i), 64'(mbus_ADATA), 64'(e_data));
      chk($sformatf("v%0d mbus_AWMSK", i), 64'(mbus_AWMSK), 64'(e_wmsk));
      chk($sformatf("v%0d mbus_AEXC", i),  64'(mbus_AEXC),  64'(e_exc));
    end
    chk($sformatf("v%0d ibus_AREADY", i), 64'(ibus_AREADY), 64'(x.iar));
    chk($sformatf("v%0d dbus_AREADY", i), 64'(dbus_AREADY), 64'(x.dar));
    chk($sformatf("v%0d ibus_BVALID", i), 64'(ibus_BVALID), 64'(x.ibv));
    chk($sformatf("v%0d dbus_BVALID", i), 64'(dbus_BVALID), 64'(x.dbv));
    chk($sformatf("v%0d mbus_BREADY", i), 64'(mbus_BREADY), 64'(x.mbr));
    if (x.ibv) begin
      chk($sformatf("v%0d ibus_BDATA", i), 64'(ibus_BDATA), 64'(e_bdata));
      chk($sformatf("v%0d ibus_BEXC", i),  64'(ibus_BEXC),  64'(x.tag[1:0]));
    end
    if (x.dbv) begin
      chk($sformatf("v%0d dbus_BDATA", i), 64'(dbus_BDATA), 64'(e_bdata));
      chk($sformatf("v%0d dbus_BEXC", i),  64'(dbus_BEXC),  64'(x.tag[1:0]));
    end
  endtask

  // Streaming run: three commands from each master against a slave with a
  // two-cycle response delay and random ready/back-pressure. Expected order of
  // responses is i0,d0,i1,d1,i2,d2 with data = addr ^ K.
  task automatic run_stream();
    logic [32:0] exp_q [$];
    logic [31:0] slv_q [$];
    int          slv_age [$];
    int          ii, di, got;
    logic        a_hs, m_b, b_i, b_d, i_acc, d_acc;
    logic [31:0] a_addr;
    logic [32:0] e;

    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, (32'h100 + 32'(k * 4)) ^ K});
      exp_q.push_back({1'b1, (32'h200 + 32'(k * 4)) ^ K});
    end
    ii = 0; di = 0; got = 0;

    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
      ibus_AVALID = (ii < 3);
      ibus_AADDR  = 32'h100 + 32'(ii * 4);
      dbus_AVALID = (di < 3);
      dbus_AADDR  = 32'h200 + 32'(di * 4);
      dbus_ADATA  = 32'hC0DE_0000 | 32'(di);
      dbus_AWMSK  = 4'h0;
      mbus_AREADY = ($urandom_range(0, 3) != 0);
      mbus_BVALID = (slv_q.size() > 0) && (slv_age[0] >= 2);
      mbus_BDATA  = (slv_q.size() > 0) ? slv_q[0] : 32'h0;
      mbus_BEXC   = 2'b00;
      ibus_BREADY = ($urandom_range(0, 2) != 0);
      dbus_BREADY = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      a_hs   = mbus_AVALID && mbus_AREADY;
      a_addr = mbus_AADDR;
      i_acc  = ibus_AVALID && ibus_AREADY;
      d_acc  = dbus_AVALID && dbus_AREADY;
      m_b    = mbus_BVALID && mbus_BREADY;
      b_i    = ibus_BVALID && ibus_BREADY;
      b_d    = dbus_BVALID && dbus_BREADY;
      if (b_i || b_d) begin
        if (exp_q.size() == 0) begin
          chk("stream unexpected response", 64'(got), 64'd6);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream rsp%0d id", got), 64'(b_d), 64'(e[32]));
          chk($sformatf("stream rsp%0d data", got),
              64'(b_d ? dbus_BDATA : ibus_BDATA), 64'(e[31:0]));
          got++;
        end
      end
      chk($sformatf("stream c%0d b one-hot", cyc), 64'(b_i && b_d), 64'd0);
      @(posedge clk);
      #1;
      for (int k = 0; k < slv_age.size(); k++) slv_age[k]++;
      if (m_b) begin
        void'(slv_q.pop_front());
        void'(slv_age.pop_front());
      end
      if (a_hs) begin
        slv_q.push_back(a_addr ^ K);
        slv_age.push_back(0);
      end
      if (i_acc) ii++;
      if (d_acc) di++;
    end
    chk("stream responses received", 64'(got), 64'd6);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //                   tag     rst iv dv ar bv ibr dbr   mav sel iar dar ibv dbv mbr
    // reset held with both masters requesting
    vecs[0]  = mk(8'd1,  7'b0111011, 7'b0000000);
    vecs[1]  = mk(8'd2,  7'b0111011, 7'b0000000);
    // contention: ibus first after reset, then alternate; responses in order
    vecs[2]  = mk(8'd3,  7'b1111011, 7'b1010000);
    vecs[3]  = mk(8'd4,  7'b1111011, 7'b1101001);
    vecs[4]  = mk(8'd5,  7'b1111111, 7'b0000101);
    vecs[5]  = mk(8'd6,  7'b1111111, 7'b1010011);
    vecs[6]  = mk(8'd7,  7'b1111111, 7'b1101101);
    vecs[7]  = mk(8'd8,  7'b1001111, 7'b0010011);
    vecs[8]  = mk(8'd9,  7'b1000011, 7'b0000000);
    // stall lock on dbus while ibus also requests
    vecs[9]  = mk(8'd10, 7'b1010011, 7'b1100000);
    vecs[10] = mk(8'd10, 7'b1110011, 7'b1100000);
    vecs[11] = mk(8'd10, 7'b1110011, 7'b1100000);
    vecs[12] = mk(8'd10, 7'b1111011, 7'b1101000);
    vecs[13] = mk(8'd14, 7'b1101011, 7'b1010001);
    // full: blocked, pop cycle still blocked
    vecs[14] = mk(8'd15, 7'b1111011, 7'b0000001);
    vecs[15] = mk(8'd16, 7'b1111111, 7'b0000011);
    // back-pressure with ibus at head
    vecs[16] = mk(8'd17, 7'b1001101, 7'b0010100);
    vecs[17] = mk(8'd18, 7'b1001101, 7'b0010100);
    vecs[18] = mk(8'd19, 7'b1001111, 7'b0010101);
    // spurious response with nothing outstanding
    vecs[19] = mk(8'd20, 7'b1000111, 7'b0000000);
    // fill, reset mid-operation, spurious response, ibus first again
    vecs[20] = mk(8'd21, 7'b1111011, 7'b1101000);
    vecs[21] = mk(8'd22, 7'b1111011, 7'b1010001);
    vecs[22] = mk(8'd23, 7'b0111111, 7'b0000000);
    vecs[23] = mk(8'd24, 7'b1000111, 7'b0000000);
    vecs[24] = mk(8'd25, 7'b1111011, 7'b1010000);

    drive_idle();
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive_vec(v);
      @(negedge clk);
      check_vec(i, v);
      @(posedge clk);
      #1;
    end

    run_stream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
